pbkdf2_iter_ctrl: RTL and testbench
===================================

Name: pbkdf2_iter_ctrl

Overview:
- Iteration sequencer for one PBKDF2-HMAC-SHA256 output block (dkLen = 32 bytes, block index 1).
- Sits between the top-level request interface and a single shared hmac_sha256 instance. It drives that instance's key/msg/len/valid-ready ports.
- Computes U1 = HMAC(P, S || INT(1)) and Uj = HMAC(P, Uj-1) for j = 2..c, and accumulates T = U1 ^ ... ^ Uc.
- Returns T once all c iterations complete.

Parameters:
- ITER_W, 32, width of the iteration count c. Supported range is 1..2^ITER_W-1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- v_i  in  1  request valid.
- r_o  out  1  ready to accept a request.
- pass_i  in  512  password P, left-aligned, zero-filled on the right.
- salt_i  in  512  salt S, left-aligned.
- salt_len_i  in  6  salt length in bytes.
- iter_i  in  ITER_W  iteration count c.
- v_o  out  1  result valid.
- r_i  in  1  consumer ready.
- dk_o  out  256  derived key T.
- err_o  out  1  request rejected; qualified by v_o.
- hmac_key_o  out  512  key to the HMAC core.
- hmac_msg_o  out  512  message to the HMAC core, left-aligned.
- hmac_msg_len_o  out  6  message length in bytes.
- hmac_v_o  out  1  HMAC request valid.
- hmac_r_i  in  1  HMAC core accepts the request.
- hmac_prf_i  in  256  HMAC result.
- hmac_v_i  in  1  HMAC result valid.
- hmac_r_o  out  1  controller accepts the HMAC result.

Behaviour:
- Reset (asynchronous, rst_ni=0):
  - State goes to IDLE.
  - All registers clear: pass/salt/len/iter copies, U, accumulator, counter, err.
  - Outputs during and after reset: r_o=1, v_o=0, err_o=0, dk_o=0, hmac_v_o=0, hmac_r_o=0, hmac_* data=0.
  - Reset mid-operation abandons the job. No further HMAC handshake is issued.
- Handshakes: a transfer occurs on any cycle where valid && ready. Valid, once raised, holds until the transfer. Data is held stable while valid is high.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - r_o=1.
  - On v_i: register all inputs and set cnt=0.
  - If iter_i==0 or salt_len_i>51, set err=1, clear the accumulator, and go to DONE. No HMAC transaction is issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - hmac_v_o=1 and hmac_key_o = registered P.
  - When cnt==0:
    - hmac_msg_o = (salt masked to salt_len bytes, bytes >= salt_len forced to 0) | (32'h00000001 << (480 - 8*salt_len)).
    - hmac_msg_len_o = salt_len+4.
  - When cnt>0:
    - hmac_msg_o = {U, 256'b0}.
    - hmac_msg_len_o = 32.
  - On hmac_r_i, go to WAIT.
- WAIT:
  - hmac_r_o=1, hmac_v_o=0.
  - On hmac_v_i, do all of the following in one cycle:
    - U <= hmac_prf_i.
    - acc <= (cnt==0) ? hmac_prf_i : acc ^ hmac_prf_i.
    - cnt <= cnt+1.
  - If cnt+1 == iter, go to DONE; else go to ISSUE.
- DONE:
  - v_o=1, dk_o=acc, err_o=err.
  - On r_i, go to IDLE and clear err.
  - dk_o holds its value outside DONE; only v_o qualifies it.
- Result timing: hmac_prf_i is captured only on the hmac_v_i && hmac_r_o cycle. Any hmac_v_i outside WAIT is ignored.
- Latency: 1 cycle from request accept to hmac_v_o. Back-to-back HMAC issue occurs the cycle after each result. Result v_o is asserted the cycle after the final HMAC result.
- Counter: ITER_W bits, no wrap. The comparison cnt+1==iter is done at ITER_W+1 bits. iter = 2^ITER_W-1 must complete correctly.
- Simultaneous events: in DONE, v_i is ignored because r_o=0. A new request is accepted no earlier than the cycle after the r_i handshake.
- Stalls: hmac_r_i or r_i held low keeps the state, with all outputs stable.

Test Plan:
- P="password", S="salt" (len 4), c=1 -> one HMAC transaction with msg_len=8, msg="salt"||00000001. Then dk_o = 120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b, err_o=0.
- Same P/S, c=2 -> second HMAC has msg_len=32 and msg={U1, 0}. dk_o = ae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43.
- Same P/S, c=4096, with random stalls on hmac_r_i, hmac_v_i and r_i -> exactly 4096 HMAC handshakes. dk_o = c5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a.
- iter_i=0, then salt_len_i=52 -> v_o the cycle after accept with err_o=1, dk_o=0, and hmac_v_o never asserted.
- Pull rst_ni low during WAIT of the 3rd iteration of a c=10 job -> outputs go to reset values immediately. A following c=1 "password"/"salt" job returns 120fb6cf...e17b.
- salt_len_i=51 with garbage bytes above the length -> msg_len=55. Bytes 51..54 = 00 00 00 01 and bytes 55..63 = 0.

Source files
------------

// File: rtl/pbkdf2_iter_ctrl.sv
// PBKDF2-HMAC-SHA256 iteration sequencer for a single 32-byte output block (block index 1).
// Drives one shared HMAC core and XOR-accumulates U1..Uc into the derived key T.
module pbkdf2_iter_ctrl #(
  parameter int unsigned ITER_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              v_i,
  output logic              r_o,
  input  logic [511:0]      pass_i,
  input  logic [511:0]      salt_i,
  input  logic [5:0]        salt_len_i,
  input  logic [ITER_W-1:0] iter_i,
  output logic              v_o,
  input  logic              r_i,
  output logic [255:0]      dk_o,
  output logic              err_o,
  output logic [511:0]      hmac_key_o,
  output logic [511:0]      hmac_msg_o,
  output logic [5:0]        hmac_msg_len_o,
  output logic              hmac_v_o,
  input  logic              hmac_r_i,
  input  logic [255:0]      hmac_prf_i,
  input  logic              hmac_v_i,
  output logic              hmac_r_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            state_q;
  logic [511:0]      pass_q;
  logic [511:0]      salt_q;
  logic [5:0]        salt_len_q;
  logic [ITER_W-1:0] iter_q;
  logic [ITER_W-1:0] cnt_q;
  logic [255:0]      u_q;
  logic [255:0]      acc_q;
  logic              err_q;

  // One extra bit so iter = 2^ITER_W-1 terminates without the counter wrapping.
  logic [ITER_W:0] cnt_inc;
  assign cnt_inc = {1'b0, cnt_q} + {{ITER_W{1'b0}}, 1'b1};

  // First message: salt truncated to its length, followed by INT(1) big-endian.
  logic [8:0]   salt_bits;
  logic [511:0] salt_mask;
  logic [511:0] first_msg;
  assign salt_bits = {salt_len_q, 3'b000};
  assign salt_mask = ~({512{1'b1}} >> salt_bits);
  assign first_msg = (salt_q & salt_mask) | (512'd1 << (9'd480 - salt_bits));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      pass_q     <= '0;
      salt_q     <= '0;
      salt_len_q <= '0;
      iter_q     <= '0;
      cnt_q      <= '0;
      u_q        <= '0;
      acc_q      <= '0;
      err_q      <= 1'b0;
      r_o        <= 1'b1;
      v_o        <= 1'b0;
      hmac_v_o   <= 1'b0;
      hmac_r_o   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (v_i) begin
            pass_q     <= pass_i;
            salt_q     <= salt_i;
            salt_len_q <= salt_len_i;
            iter_q     <= iter_i;
            cnt_q      <= '0;
            r_o        <= 1'b0;
            if (iter_i == '0 || salt_len_i > 6'd51) begin
              err_q   <= 1'b1;
              acc_q   <= '0;
              v_o     <= 1'b1;
              state_q <= StDone;
            end else begin
              hmac_v_o <= 1'b1;
              state_q  <= StIssue;
            end
          end
        end
        StIssue: begin
          if (hmac_r_i) begin
            hmac_v_o <= 1'b0;
            hmac_r_o <= 1'b1;
            state_q  <= StWait;
          end
        end
        StWait: begin
          if (hmac_v_i) begin
            u_q      <= hmac_prf_i;
            acc_q    <= (cnt_q == '0) ? hmac_prf_i : (acc_q ^ hmac_prf_i);
            cnt_q    <= cnt_inc[ITER_W-1:0];
            hmac_r_o <= 1'b0;
            if (cnt_inc == {1'b0, iter_q}) begin
              v_o     <= 1'b1;
              state_q <= StDone;
            end else begin
              hmac_v_o <= 1'b1;
              state_q  <= StIssue;
            end
          end
        end
        StDone: begin
          if (r_i) begin
            err_q   <= 1'b0;
            v_o     <= 1'b0;
            r_o     <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    hmac_key_o     = '0;
    hmac_msg_o     = '0;
    hmac_msg_len_o = '0;
    if (state_q == StIssue) begin
      hmac_key_o = pass_q;
      if (cnt_q == '0) begin
        hmac_msg_o     = first_msg;
        hmac_msg_len_o = salt_len_q + 6'd4;
      end else begin
        hmac_msg_o     = {u_q, 256'b0};
        hmac_msg_len_o = 6'd32;
      end
    end
  end

  assign dk_o  = acc_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_pbkdf2_iter_ctrl.sv
// Randomized bench for pbkdf2_iter_ctrl: an HMAC-SHA256 core model answers requests, and a
// job-level PBKDF2 model predicts every request, handshake and result.
module tb_pbkdf2_iter_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b1;
  logic         v_i = 1'b0;
  logic         r_o;
  logic [511:0] pass_i = '0;
  logic [511:0] salt_i = '0;
  logic [5:0]   salt_len_i = '0;
  logic [31:0]  iter_i = '0;
  logic         v_o;
  logic         r_i = 1'b0;
  logic [255:0] dk_o;
  logic         err_o;
  logic [511:0] hmac_key_o;
  logic [511:0] hmac_msg_o;
  logic [5:0]   hmac_msg_len_o;
  logic         hmac_v_o;
  logic         hmac_r_i = 1'b0;
  logic [255:0] hmac_prf_i = '0;
  logic         hmac_v_i = 1'b0;
  logic         hmac_r_o;

  pbkdf2_iter_ctrl #(.ITER_W(32)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .v_i            (v_i),
    .r_o            (r_o),
    .pass_i         (pass_i),
    .salt_i         (salt_i),
    .salt_len_i     (salt_len_i),
    .iter_i         (iter_i),
    .v_o            (v_o),
    .r_i            (r_i),
    .dk_o           (dk_o),
    .err_o          (err_o),
    .hmac_key_o     (hmac_key_o),
    .hmac_msg_o     (hmac_msg_o),
    .hmac_msg_len_o (hmac_msg_len_o),
    .hmac_v_o       (hmac_v_o),
    .hmac_r_i       (hmac_r_i),
    .hmac_prf_i     (hmac_prf_i),
    .hmac_v_i       (hmac_v_i),
    .hmac_r_o       (hmac_r_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- SHA-256 / HMAC / PBKDF2 reference ----------------
  localparam logic [2047:0] KTAB = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [255:0] H0 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [511:0] PW   = {64'h70617373776f7264, 448'd0};  // "password"
  localparam logic [511:0] SALT = {32'h73616c74, 480'd0};          // "salt"
  localparam logic [255:0] LIT1 =
    256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b;
  localparam logic [255:0] LIT2 =
    256'hae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43;
  localparam logic [255:0] LIT4096 =
    256'hc5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7] +
             (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) +
           KTAB[2047-32*t -: 32] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Key is exactly one 64-byte block; message (<= 55 bytes) plus padding fits one block.
  function automatic logic [255:0] hmac(input logic [511:0] key, input logic [511:0] msg,
                                        input int len);
    logic [511:0] blk;
    logic [255:0] ih;
    blk = msg & ~({512{1'b1}} >> (8 * len));
    blk = blk | ({504'd0, 8'h80} << (504 - 8 * len));
    blk[63:0] = 64'((64 + len) * 8);
    ih = compress(compress(H0, key ^ {64{8'h36}}), blk);
    return compress(compress(H0, key ^ {64{8'h5c}}), {ih, 8'h80, 184'd0, 64'd768});
  endfunction

  function automatic logic [511:0] first_msg(input logic [511:0] s, input int len);
    logic [511:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < len) m[511-8*i -: 8] = s[511-8*i -: 8];
      else if (i == len + 3) m[511-8*i -: 8] = 8'h01;
    end
    return m;
  endfunction

  function automatic logic [255:0] pbkdf2(input logic [511:0] p, input logic [511:0] s,
                                          input int len, input int c);
    logic [255:0] u, t;
    u = hmac(p, first_msg(s, len), len + 4);
    t = u;
    for (int j = 2; j <= c; j++) begin
      u = hmac(p, {u, 256'd0}, 32);
      t = t ^ u;
    end
    return t;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      if (nerr <= 20) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outs();
    chk("reset_flags", {508'd0, r_o, v_o, hmac_v_o, hmac_r_o}, 512'b1000);
    chk("reset_dk", {256'd0, dk_o}, '0);
    chk("reset_err", {511'd0, err_o}, '0);
    chk("reset_key", hmac_key_o, '0);
    chk("reset_msg", hmac_msg_o, '0);
    chk("reset_len", {506'd0, hmac_msg_len_o}, '0);
  endtask

  typedef struct {
    logic [511:0] p;
    logic [511:0] s;
    logic [5:0]   len;
    logic [31:0]  c;
    logic         lit_en;
    logic [255:0] lit;
    logic         abort;
  } job_t;

  job_t jq[$];
  job_t cur;

  localparam int PhIdle = 0, PhReq = 1, PhWait = 2, PhRes = 3;
  int           phase = PhIdle;
  int           nres, nreq, st_delay, exp_len;
  logic         armed = 1'b0, rst_hold = 1'b0, req_taken = 1'b0, st_pend = 1'b0;
  logic         cur_abort = 1'b0, cur_bad, exp_err;
  logic [511:0] exp_msg;
  logic [255:0] exp_dk, last_dk = '0, m_u, m_t, st_prf;

  task automatic add_job(input logic [511:0] p, input logic [511:0] s, input int len,
                         input int c, input logic lit_en, input logic [255:0] lit,
                         input logic abort);
    job_t j;
    j.p = p; j.s = s; j.len = 6'(len); j.c = 32'(c);
    j.lit_en = lit_en; j.lit = lit; j.abort = abort;
    jq.push_back(j);
  endtask

  // Single per-cycle process: check outputs against the model, drive inputs, then advance
  // the model by whichever handshakes the coming posedge will complete.
  initial begin : drive_check
    forever begin
      @(negedge clk_i);
      if (!armed) continue;
      if (rst_hold) begin
        rst_ni   = 1'b1;
        rst_hold = 1'b0;
      end
      chk("flags", {508'd0, r_o, v_o, hmac_v_o, hmac_r_o},
          {508'd0, phase == PhIdle, phase == PhRes, phase == PhReq, phase == PhWait});
      if (phase == PhReq) begin
        chk("hmac_key", hmac_key_o, cur.p);
        chk("hmac_msg", hmac_msg_o, exp_msg);
        chk("hmac_len", {506'd0, hmac_msg_len_o}, 512'(exp_len));
      end
      if (phase == PhRes) begin
        chk("dk", {256'd0, dk_o}, {256'd0, exp_dk});
        chk("err", {511'd0, err_o}, {511'd0, exp_err});
      end
      if (phase == PhIdle) chk("dk_hold", {256'd0, dk_o}, {256'd0, last_dk});

      // Abandon the job while it waits on the third HMAC result.
      if (cur_abort && phase == PhWait && nres == 2) begin
        rst_ni = 1'b0;
        v_i = 1'b0; hmac_v_i = 1'b0; hmac_r_i = 1'b0; r_i = 1'b0;
        #1;
        chk_reset_outs();
        phase = PhIdle; last_dk = '0; st_pend = 1'b0; cur_abort = 1'b0;
        req_taken = 1'b0; rst_hold = 1'b1;
        continue;
      end

      if (req_taken) begin
        v_i = 1'b0;
        req_taken = 1'b0;
      end
      if (!v_i) begin
        salt_len_i = 6'($urandom);
        iter_i     = $urandom;
        if (jq.size() > 0 && $urandom_range(0, 1) == 1) begin
          v_i = 1'b1;
          pass_i = jq[0].p; salt_i = jq[0].s; salt_len_i = jq[0].len; iter_i = jq[0].c;
        end
      end
      hmac_r_i = ($urandom_range(0, 3) != 0);
      if (st_pend) begin
        if (st_delay == 0) begin
          hmac_v_i = 1'b1;
          hmac_prf_i = st_prf;
        end else begin
          hmac_v_i = 1'b0;
          st_delay--;
        end
      end else begin
        // Stray results while no request is outstanding must be ignored.
        hmac_v_i = 1'b0;
        if (!(hmac_v_o && hmac_r_i) && $urandom_range(0, 7) == 0) begin
          hmac_v_i = 1'b1;
          hmac_prf_i = rand512()[255:0];
        end
      end
      r_i = ($urandom_range(0, 2) != 0);

      if (v_i && r_o) begin
        cur = jq.pop_front();
        req_taken = 1'b1; cur_abort = cur.abort;
        nres = 0; nreq = 0; m_t = '0;
        cur_bad = (cur.c == 0) || (cur.len > 6'd51);
        if (cur_bad) begin
          phase = PhRes; exp_dk = '0; exp_err = 1'b1;
        end else begin
          phase = PhReq; exp_err = 1'b0;
          exp_msg = first_msg(cur.s, int'(cur.len));
          exp_len = int'(cur.len) + 4;
        end
      end else if (hmac_v_o && hmac_r_i) begin
        phase = PhWait; nreq++;
        st_pend = 1'b1;
        st_delay = $urandom_range(0, 3);
        st_prf = hmac(hmac_key_o, hmac_msg_o, int'(hmac_msg_len_o));
      end else if (hmac_v_i && hmac_r_o) begin
        st_pend = 1'b0;
        m_u = hmac(cur.p, exp_msg, exp_len);
        m_t = (nres == 0) ? m_u : (m_t ^ m_u);
        nres++;
        if (32'(nres) == cur.c) begin
          phase = PhRes; exp_dk = m_t;
        end else begin
          phase = PhReq; exp_msg = {m_u, 256'd0}; exp_len = 32;
        end
      end else if (v_o && r_i) begin
        phase = PhIdle; last_dk = exp_dk;
        chk("hmac_count", 512'(nreq), cur_bad ? '0 : {480'd0, cur.c});
        if (cur.lit_en) chk("dk_literal", {256'd0, dk_o}, {256'd0, cur.lit});
      end
    end
  end

  initial begin : main
    logic done;
    chk("model_c1", {256'd0, pbkdf2(PW, SALT, 4, 1)}, {256'd0, LIT1});
    chk("model_c2", {256'd0, pbkdf2(PW, SALT, 4, 2)}, {256'd0, LIT2});
    #1 rst_ni = 1'b0;
    #1 chk_reset_outs();
    repeat (3) @(negedge clk_i);
    chk_reset_outs();
    rst_ni = 1'b1;
    armed  = 1'b1;

    add_job(PW, SALT, 4, 1, 1'b1, LIT1, 1'b0);
    add_job(PW, SALT, 4, 2, 1'b1, LIT2, 1'b0);
    add_job(PW, SALT, 4, 0, 1'b0, '0, 1'b0);
    add_job(PW, SALT, 52, 1, 1'b0, '0, 1'b0);
    add_job(rand512(), rand512(), 51, 1, 1'b0, '0, 1'b0);
    add_job(rand512(), rand512(), 51, 2, 1'b0, '0, 1'b0);
    for (int k = 0; k < 8; k++)
      add_job(rand512(), rand512(), $urandom_range(0, 51), $urandom_range(1, 6), 1'b0, '0, 1'b0);
    add_job(rand512(), rand512(), $urandom_range(52, 63), $urandom_range(1, 5), 1'b0, '0, 1'b0);
    add_job(rand512(), rand512(), $urandom_range(0, 51), 0, 1'b0, '0, 1'b0);
    add_job(PW, SALT, 4, 10, 1'b0, '0, 1'b1);
    add_job(PW, SALT, 4, 1, 1'b1, LIT1, 1'b0);
    add_job(PW, SALT, 4, 4096, 1'b1, LIT4096, 1'b0);

    done = 1'b0;
    for (int cyc = 0; cyc < 90000 && !done; cyc++) begin
      @(negedge clk_i);
      #2;
      done = (jq.size() == 0) && (phase == PhIdle) && !v_i && !req_taken;
    end
    nvec++;
    if (!done) begin
      nerr++;
      $display("FAIL timeout: jobs left %0d, phase %0d, required all jobs complete",
               jq.size(), phase);
    end
    repeat (2) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
